stack_sequencer: RTL
====================

Name: stack_sequencer

Overview:
Parametrised multi-cycle control sequencer in the decode stage. It generates the stack push/pop and PC-steering control sequences for CALL, RET, RETI and vectored hardware interrupts. It generalises PC width as a multiple of the memory word, the pipeline drain depth, the return settle time and the number of prioritised interrupt sources. It adds a global interrupt-enable bit that blocks nested interrupts. Its outputs are OR-merged with the combinational instruction decoder's control signals.

Parameters:
PC_WIDTH, 32, PC width in bits; must be a multiple of WORD_WIDTH
WORD_WIDTH, 16, stack/memory word width
NUM_IRQ, 4, number of interrupt request lines; index 0 has highest priority
DRAIN_CYCLES, 5, cycles the pipeline drains before interrupt entry pushes (>=1)
RET_WAIT, 2, cycles after the last PC pop while the pipeline is flushed (>=1)
(derived localparams) PC_WORDS = PC_WIDTH/WORD_WIDTH; SELW = $clog2(PC_WORDS+1); IDW = max(1,$clog2(NUM_IRQ))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
irq_req  in  NUM_IRQ  level interrupt requests
seq_valid  in  1  decode holds a sequenced instruction
seq_op  in  2  00 NONE, 01 CALL, 10 RET, 11 RETI
seq_busy  out  1  stall fetch/decode
pc_write_en  out  1  PC register write enable
mem_push, mem_pop, mem_write, mem_read  out  1 each  memory-stage stack controls
push_sel  out  SELW  push source: 0 = flags, k = PC word k (1 = most significant)
pop_dst  out  SELW  destination of popped word, same encoding
flag_restore  out  1  flag register loads from the pop path
pc_from_mem  out  1  PC mux selects the reassembled popped PC
pc_from_vector  out  1  PC mux selects the vector table entry
vector_id  out  IDW  accepted interrupt index
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge
jump_uncond  out  1  execute-stage unconditional jump (CALL target)
clear_instruction  out  1  flush decode
int_en  out  1  global interrupt enable

Behaviour:
- Reset (async, reset=0): state IDLE, counters 0, latched id 0, int_en=1. All outputs 0 except pc_write_en=1.
- States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR, CALL_PUSH, POP_FLAGS, POP_PC, RET_FLUSH.
- All outputs are decoded from registered state/counter only (Moore). Exception: seq_busy is also 1 combinationally in IDLE when an interrupt is accepted, or when seq_valid=1 and seq_op!=NONE.
- IDLE, interrupt accept: condition is int_en & |irq_req. Latch the lowest set index and go to DRAIN. Interrupt beats a same-cycle seq_valid; the instruction is not consumed and is re-presented after return.
- IDLE, ops: CALL -> CALL_PUSH. RET -> POP_PC. RETI -> POP_FLAGS. seq_valid with NONE -> no action.
- DRAIN: exactly DRAIN_CYCLES cycles with seq_busy=1, pc_write_en=0, then PUSH_PC.
- PUSH_PC: PC_WORDS cycles with mem_push=mem_write=1, seq_busy=1, pc_write_en=0. push_sel goes 1,2,..,PC_WORDS (MS word first). Then PUSH_FLAGS.
- PUSH_FLAGS: 1 cycle, push_sel=0, push/write=1. Then VECTOR.
- VECTOR: 1 cycle with pc_from_vector=1, pc_write_en=1, vector_id=latched id, irq_ack[id]=1. int_en clears at the end of this cycle. Next state IDLE.
- Interrupt entry latency, accept to VECTOR inclusive: DRAIN_CYCLES+PC_WORDS+2 cycles.
- CALL_PUSH: PC_WORDS cycles pushing PC words MS-first with seq_busy=1. jump_uncond=1 on the last word. Then IDLE.
- POP_FLAGS: 1 cycle with mem_pop=mem_read=1, pop_dst=0, flag_restore=1. Then POP_PC.
- POP_PC: PC_WORDS cycles with pop/read=1, clear_instruction=1. pop_dst goes PC_WORDS..1 (LS word first, strict LIFO). Then RET_FLUSH.
- RET_FLUSH: RET_WAIT cycles with clear_instruction=1. Cycle 0 only: pc_from_mem=1, pc_write_en=1. On exit, int_en is set if the entry was RETI. Then IDLE.
- irq_req while not IDLE or while int_en=0: ignored, stays pending (level). Deassertion after accept does not abort the entry sequence.
- RET without a prior push: no checking; stack contents are the software's responsibility.
- Counters: width $clog2(max(DRAIN_CYCLES,PC_WORDS,RET_WAIT)+1); zeroed on every state change; no wrap.

Decomposition:
- Package stack_seq_pkg holds: state enum, seq_op encodings, and the push_sel/pop_dst code for flags (0).
- One sub-module, irq_prio_enc: NUM_IRQ-wide fixed-priority encoder with enable input. Outputs are a valid bit and an index.

Test Plan:
Defaults unless stated (PC_WORDS=2, DRAIN_CYCLES=5, RET_WAIT=2).
- irq_req=4'b0110 in IDLE, int_en=1 -> 5 DRAIN cycles; push_sel 1,2,0 over 3 cycles; VECTOR with vector_id=1 and irq_ack=4'b0010; int_en=0; total 9 cycles.
- CALL in IDLE -> 2 push cycles, push_sel 1 then 2; jump_uncond=1 only on the 2nd; seq_busy high throughout; back to IDLE.
- RETI after an interrupt -> pop_dst 0,2,1 with flag_restore on the first; pc_from_mem and pc_write_en for 1 cycle; clear_instruction for 4 cycles; int_en=1 on exit.
- irq_req=4'b0001 held during a RET sequence, and again while int_en=0 -> not accepted; accepted the cycle after RETI completes.
- reset driven low mid-PUSH_PC -> immediately IDLE, all outputs at reset values, int_en=1, no further pushes.
- Parameter sweep PC_WIDTH=48, NUM_IRQ=1, DRAIN_CYCLES=1 -> 3 PC pushes; vector_id width 1; entry latency 6 cycles.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared types and encodings for the stack sequencer: FSM states, sequenced
// opcodes and the push/pop selector code reserved for the flag register.
package stack_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLAGS,
    S_VECTOR,
    S_CALL_PUSH,
    S_POP_FLAGS,
    S_POP_PC,
    S_RET_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_RETI = 2'b11
  } seq_op_e;

  localparam int unsigned SEL_FLAGS = 0;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: lowest set request index wins, gated by en.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               en,
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDW-1:0]     idx
);

  // Scan from the top down so the lowest index overwrites last.
  always_comb begin
    valid = en & (|req);
    idx   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Decode-stage sequencer producing stack push/pop and PC-steering control for
// CALL, RET, RETI and vectored interrupts; outputs are Moore except seq_busy.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned RET_WAIT     = 2,
  localparam int unsigned PC_WORDS    = PC_WIDTH / WORD_WIDTH,
  localparam int unsigned SELW        = $clog2(PC_WORDS + 1),
  localparam int unsigned IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               seq_valid,
  input  logic [1:0]         seq_op,
  output logic               seq_busy,
  output logic               pc_write_en,
  output logic               mem_push,
  output logic               mem_pop,
  output logic               mem_write,
  output logic               mem_read,
  output logic [SELW-1:0]    push_sel,
  output logic [SELW-1:0]    pop_dst,
  output logic               flag_restore,
  output logic               pc_from_mem,
  output logic               pc_from_vector,
  output logic [IDW-1:0]     vector_id,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               jump_uncond,
  output logic               clear_instruction,
  output logic               int_en
);

  localparam int unsigned CNT_MAX = max3(DRAIN_CYCLES, PC_WORDS, RET_WAIT);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            reti_q, reti_d;
  logic            int_en_d;

  logic            irq_valid;
  logic [IDW-1:0]  irq_idx;
  logic            drain_last;
  logic            words_last;
  logic            wait_last;
  seq_op_e         op;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDW     (IDW)
  ) u_prio (
    .en    (int_en),
    .req   (irq_req),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  assign op         = seq_op_e'(seq_op);
  assign drain_last = (cnt_q == CW'(DRAIN_CYCLES - 1));
  assign words_last = (cnt_q == CW'(PC_WORDS - 1));
  assign wait_last  = (cnt_q == CW'(RET_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      reti_q  <= 1'b0;
      int_en  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      reti_q  <= reti_d;
      int_en  <= int_en_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    id_d              = id_q;
    reti_d            = reti_q;
    int_en_d          = int_en;
    seq_busy          = 1'b1;
    pc_write_en       = 1'b0;
    mem_push          = 1'b0;
    mem_pop           = 1'b0;
    mem_write         = 1'b0;
    mem_read          = 1'b0;
    push_sel          = '0;
    pop_dst           = '0;
    flag_restore      = 1'b0;
    pc_from_mem       = 1'b0;
    pc_from_vector    = 1'b0;
    vector_id         = '0;
    irq_ack           = '0;
    jump_uncond       = 1'b0;
    clear_instruction = 1'b0;

    case (state_q)
      // Interrupts take precedence; the pending instruction is left in decode.
      S_IDLE: begin
        seq_busy    = irq_valid | (seq_valid & (op != OP_NONE));
        pc_write_en = 1'b1;
        if (irq_valid) begin
          state_d = S_DRAIN;
          id_d    = irq_idx;
        end else if (seq_valid) begin
          case (op)
            OP_CALL: state_d = S_CALL_PUSH;
            OP_RET: begin
              state_d = S_POP_PC;
              reti_d  = 1'b0;
            end
            OP_RETI: begin
              state_d = S_POP_FLAGS;
              reti_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_DRAIN: begin
        if (drain_last) state_d = S_PUSH_PC;
      end
      S_PUSH_PC: begin
        mem_push  = 1'b1;
        mem_write = 1'b1;
        push_sel  = SELW'(cnt_q) + SELW'(1);
        if (words_last) state_d = S_PUSH_FLAGS;
      end
      S_PUSH_FLAGS: begin
        mem_push  = 1'b1;
        mem_write = 1'b1;
        push_sel  = SELW'(SEL_FLAGS);
        state_d   = S_VECTOR;
      end
      S_VECTOR: begin
        pc_write_en    = 1'b1;
        pc_from_vector = 1'b1;
        vector_id      = id_q;
        irq_ack        = NUM_IRQ'(1) << id_q;
        int_en_d       = 1'b0;
        state_d        = S_IDLE;
      end
      S_CALL_PUSH: begin
        mem_push    = 1'b1;
        mem_write   = 1'b1;
        push_sel    = SELW'(cnt_q) + SELW'(1);
        jump_uncond = words_last;
        if (words_last) state_d = S_IDLE;
      end
      S_POP_FLAGS: begin
        mem_pop      = 1'b1;
        mem_read     = 1'b1;
        pop_dst      = SELW'(SEL_FLAGS);
        flag_restore = 1'b1;
        state_d      = S_POP_PC;
      end
      // Words come back in reverse push order: least significant first.
      S_POP_PC: begin
        mem_pop           = 1'b1;
        mem_read          = 1'b1;
        clear_instruction = 1'b1;
        pop_dst           = SELW'(PC_WORDS) - SELW'(cnt_q);
        if (words_last) state_d = S_RET_FLUSH;
      end
      S_RET_FLUSH: begin
        clear_instruction = 1'b1;
        pc_from_mem       = (cnt_q == '0);
        pc_write_en       = (cnt_q == '0);
        if (wait_last) begin
          state_d = S_IDLE;
          if (reti_q) int_en_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + CW'(1);
  end

endmodule
